// File: rtl/postfix_eval_pkg.sv
// Shared constants for the postfix evaluator: operator character codes, error codes, FSM states.
// The divide operator is only accepted when POSTFIX_EVAL_DIV_EN is defined.
package postfix_eval_pkg;

  localparam logic [7:0] ADD  = 8'd43;
  localparam logic [7:0] SUB  = 8'd45;
  localparam logic [7:0] MUL  = 8'd42;
  localparam logic [7:0] DIV  = 8'd47;
  localparam logic [7:0] LPAR = 8'd40;
  localparam logic [7:0] RPAR = 8'd41;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_UNDER   = 3'd1;
  localparam logic [2:0] ERR_OVER    = 3'd2;
  localparam logic [2:0] ERR_ILLEGAL = 3'd3;
  localparam logic [2:0] ERR_DEPTH   = 3'd4;
  localparam logic [2:0] ERR_DIVZERO = 3'd5;

  typedef enum logic [1:0] {RUN, EXEC, DONE, DRAIN} state_e;

endpackage

// File: rtl/postfix_eval_alu.sv
// Combinational operator unit: result = a <op> b, modulo 2^WIDTH.
// Unsigned divide exists only when POSTFIX_EVAL_DIV_EN is defined; otherwise '/' is illegal.
module postfix_eval_alu
  import postfix_eval_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             divzero
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    divzero = 1'b0;
    case (op)
      ADD: result = a + b;
      SUB: result = a - b;
      MUL: result = a * b;
`ifdef POSTFIX_EVAL_DIV_EN
      DIV: begin
        if (b == '0) divzero = 1'b1;
        else         result  = a / b;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/postfix_eval_ctrl.sv
// Postfix expression sequencer: operand stack, token handshake and one result per expression.
// Optional '/' support is selected with POSTFIX_EVAL_DIV_EN.
//   state | meaning
//   RUN   | accept tokens; operands push, operators latch and move to EXEC
//   EXEC  | apply latched operator to the top two entries (stalls input)
//   DONE  | publish result/error, clear stack and error
//   DRAIN | error latched; discard tokens until tok_last
module postfix_eval_ctrl
  import postfix_eval_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 11
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       tok_valid,
  output logic                       tok_ready,
  input  logic                       tok_is_op,
  input  logic [7:0]                 tok_data,
  input  logic                       tok_last,
  output logic                       res_valid,
  output logic [WIDTH-1:0]           res_data,
  output logic [2:0]                 res_err,
  output logic [$clog2(DEPTH+1)-1:0] stack_level
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

  state_e           state_q, state_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [2:0]       err_q, err_d;
  logic [7:0]       op_q, op_d;
  logic             last_q, last_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [2:0]       res_err_q, res_err_d;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             wr_en;
  logic [SPW-1:0]   wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] top_val, next_val, alu_res;
  logic [7:0]       alu_op;
  logic             alu_illegal, alu_divzero;
  logic             accept;

  assign tok_ready   = !RST && (state_q == RUN || state_q == DRAIN);
  assign accept      = tok_valid && tok_ready;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign stack_level = sp_q;

  assign top_val  = (sp_q >= SP_ONE) ? stack_q[sp_q - SP_ONE] : '0;
  assign next_val = (sp_q >= SP_TWO) ? stack_q[sp_q - SP_TWO] : '0;
  // In RUN the ALU only screens the incoming operator code for legality.
  assign alu_op   = (state_q == EXEC) ? op_q : tok_data;

  postfix_eval_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (alu_op),
    .a       (next_val),
    .b       (top_val),
    .result  (alu_res),
    .illegal (alu_illegal),
    .divzero (alu_divzero)
  );

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    err_d       = err_q;
    op_d        = op_q;
    last_d      = last_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    wr_en       = 1'b0;
    wr_idx      = sp_q;
    wr_data     = WIDTH'(tok_data);
    case (state_q)
      RUN: begin
        if (accept) begin
          if (!tok_is_op) begin
            if (sp_q == SP_FULL) begin
              err_d   = ERR_OVER;
              state_d = tok_last ? DONE : DRAIN;
            end else begin
              wr_en   = 1'b1;
              sp_d    = sp_q + SP_ONE;
              state_d = tok_last ? DONE : RUN;
            end
          end else if (alu_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = tok_last ? DONE : DRAIN;
          end else if (sp_q < SP_TWO) begin
            err_d   = ERR_UNDER;
            state_d = tok_last ? DONE : DRAIN;
          end else begin
            op_d    = tok_data;
            last_d  = tok_last;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (alu_divzero) begin
          err_d   = ERR_DIVZERO;
          state_d = last_q ? DONE : DRAIN;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = sp_q - SP_TWO;
          wr_data = alu_res;
          sp_d    = sp_q - SP_ONE;
          state_d = last_q ? DONE : RUN;
        end
      end
      DRAIN: begin
        if (accept && tok_last) state_d = DONE;
      end
      DONE: begin
        res_valid_d = 1'b1;
        res_data_d  = '0;
        if (err_q != ERR_OK)    res_err_d = err_q;
        else if (sp_q != SP_ONE) res_err_d = ERR_DEPTH;
        else begin
          res_err_d  = ERR_OK;
          res_data_d = top_val;
        end
        sp_d    = '0;
        err_d   = ERR_OK;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      sp_q        <= '0;
      err_q       <= ERR_OK;
      op_q        <= '0;
      last_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      err_q       <= err_d;
      op_q        <= op_d;
      last_q      <= last_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Stack contents need no reset: sp bounds every read.
  always_ff @(posedge CLK) begin
    if (wr_en) stack_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_postfix_eval_ctrl.sv
// Directed self-checking bench for postfix_eval_ctrl (default WIDTH=8, DEPTH=11).
// Division cases follow POSTFIX_EVAL_DIV_EN.
module tb_postfix_eval_ctrl;
  import postfix_eval_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tok_valid = 1'b0;
  logic       tok_is_op = 1'b0;
  logic [7:0] tok_data = 8'd0;
  logic       tok_last = 1'b0;
  logic       tok_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic [2:0] res_err;
  logic [3:0] stack_level;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int res_cnt = 0;
  int res_cyc = 0;
  logic [7:0] last_data;
  logic [2:0] last_err;
  logic [8:0] tq[$];

  postfix_eval_ctrl #(.WIDTH(8), .DEPTH(11)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_is_op   (tok_is_op),
    .tok_data    (tok_data),
    .tok_last    (tok_last),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_err     (res_err),
    .stack_level (stack_level)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // res_cyc is the edge at which the pulse is sampled high.
  always @(negedge CLK) begin
    if (res_valid) begin
      res_cnt   <= res_cnt + 1;
      last_data <= res_data;
      last_err  <= res_err;
      res_cyc   <= cyc + 1;
    end
  end

  task automatic send_tok(input logic op, input logic [7:0] d, input logic last);
    int w;
    w = 0;
    @(negedge CLK);
    tok_valid = 1'b1; tok_is_op = op; tok_data = d; tok_last = last;
    while (!tok_ready && w < 50) begin
      @(negedge CLK);
      w++;
    end
    n_cmp++;
    if (tok_ready !== 1'b1) begin
      $display("FAIL handshake_wait: tok_ready=%b after %0d cycles, required 1", tok_ready, w);
      n_mis++;
    end
    @(posedge CLK);
    #1;
    acc_cyc   = cyc;
    tok_valid = 1'b0;
  endtask

  task automatic wait_result(input int n0, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      #1;
      if (res_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      $display("FAIL result_timeout: no res_valid within 40 cycles, required one");
      n_mis++;
    end
  endtask

  task automatic num(input logic [7:0] v);
    tq.push_back({1'b0, v});
  endtask

  task automatic opr(input logic [7:0] c);
    tq.push_back({1'b1, c});
  endtask

  task automatic run_expr(input bit gaps, output logic [7:0] d, output logic [2:0] e, output int lat);
    int n0, acc0;
    logic ok;
    n0 = res_cnt;
    acc0 = 0;
    for (int i = 0; i < tq.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_tok(tq[i][8], tq[i][7:0], i == tq.size() - 1);
      if (i == 0) acc0 = acc_cyc;
    end
    tq.delete();
    wait_result(n0, ok);
    d   = ok ? last_data : 8'hxx;
    e   = ok ? last_err : 3'bxxx;
    lat = res_cyc - acc0;
  endtask

  task automatic check_res(input string name, input logic [7:0] d, input logic [2:0] e,
                           input logic [7:0] exp_d, input logic [2:0] exp_e);
    n_cmp++;
    if (d !== exp_d || e !== exp_e) begin
      $display("FAIL %s: got data=%0d err=%0d, required data=%0d err=%0d", name, d, e, exp_d, exp_e);
      n_mis++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (tok_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'd0 ||
        res_err !== 3'd0 || stack_level !== 4'd0) begin
      $display("FAIL reset_state: ready=%b valid=%b data=%0d err=%0d level=%0d, required 0 0 0 0 0",
               tok_ready, res_valid, res_data, res_err, stack_level);
      n_mis++;
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (tok_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b, required 1", tok_ready);
      n_mis++;
    end
  endtask

  task automatic test_normal();
    logic [7:0] d; logic [2:0] e; int lat; int n0;
    n0 = res_cnt;
    num(5); num(4); num(2); opr(SUB); num(1); opr(ADD); opr(MUL); num(6); opr(SUB);
    run_expr(1'b0, d, e, lat);
    check_res("normal_eval", d, e, 8'd9, 3'd0);
    n_cmp++;
    if (lat !== 14) begin
      $display("FAIL normal_latency: got %0d cycles, required 14", lat);
      n_mis++;
    end
    n_cmp++;
    if (stack_level !== 4'd0) begin
      $display("FAIL normal_level_after: got %0d, required 0", stack_level);
      n_mis++;
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (res_cnt !== n0 + 1 || res_data !== 8'd9) begin
      $display("FAIL normal_single_pulse: pulses=%0d data=%0d, required 1 and held 9", res_cnt - n0, res_data);
      n_mis++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d; logic [2:0] e; int lat;
    num(200); num(100); opr(ADD);
    run_expr(1'b0, d, e, lat);
    check_res("wrap_add", d, e, 8'd44, 3'd0);
    num(3); num(5); opr(SUB);
    run_expr(1'b0, d, e, lat);
    check_res("wrap_sub", d, e, 8'd254, 3'd0);
    num(16); num(16); opr(MUL);
    run_expr(1'b0, d, e, lat);
    check_res("wrap_mul", d, e, 8'd0, 3'd0);
  endtask

  task automatic test_malformed();
    logic [7:0] d; logic [2:0] e; int lat; int n0;
    num(3); opr(ADD);
    run_expr(1'b0, d, e, lat);
    check_res("underflow", d, e, 8'd0, 3'd1);
    num(2); num(3);
    run_expr(1'b0, d, e, lat);
    check_res("bad_depth", d, e, 8'd0, 3'd4);
    n0 = res_cnt;
    num(9); num(8); opr(LPAR); num(1); num(2); opr(ADD);
    run_expr(1'b0, d, e, lat);
    check_res("illegal_lpar_drain", d, e, 8'd0, 3'd3);
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (res_cnt !== n0 + 1 || stack_level !== 4'd0) begin
      $display("FAIL illegal_single_result: pulses=%0d level=%0d, required 1 and 0", res_cnt - n0, stack_level);
      n_mis++;
    end
  endtask

  task automatic test_overflow();
    logic ok; int n0;
    n0 = res_cnt;
    for (int i = 1; i <= 12; i++) send_tok(1'b0, 8'(i), 1'b0);
    n_cmp++;
    if (tok_ready !== 1'b1 || stack_level !== 4'd11 || res_cnt !== n0) begin
      $display("FAIL overflow_drain_state: ready=%b level=%0d pulses=%0d, required 1 11 0",
               tok_ready, stack_level, res_cnt - n0);
      n_mis++;
    end
    send_tok(1'b0, 8'd13, 1'b0);
    send_tok(1'b1, ADD, 1'b1);
    wait_result(n0, ok);
    check_res("overflow", last_data, last_err, 8'd0, 3'd2);
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (res_cnt !== n0 + 1) begin
      $display("FAIL overflow_single_result: pulses=%0d, required 1", res_cnt - n0);
      n_mis++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic [2:0] e; int lat;
    num(5); num(4); num(2); opr(SUB); num(1); opr(ADD); opr(MUL); num(6); opr(SUB);
    run_expr(1'b1, d, e, lat);
    check_res("gapped_eval", d, e, 8'd9, 3'd0);
  endtask

  task automatic test_reset_in_exec();
    logic [7:0] d; logic [2:0] e; int lat; int n0;
    n0 = res_cnt;
    send_tok(1'b0, 8'd4, 1'b0);
    send_tok(1'b0, 8'd5, 1'b0);
    send_tok(1'b1, ADD, 1'b0);
    n_cmp++;
    if (tok_ready !== 1'b0) begin
      $display("FAIL exec_stall: tok_ready=%b, required 0", tok_ready);
      n_mis++;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (stack_level !== 4'd0 || tok_ready !== 1'b0) begin
      $display("FAIL reset_exec_state: level=%0d ready=%b, required 0 0", stack_level, tok_ready);
      n_mis++;
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (tok_ready !== 1'b1) begin
      $display("FAIL reset_exec_ready: got %b, required 1", tok_ready);
      n_mis++;
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (res_cnt !== n0) begin
      $display("FAIL reset_exec_no_result: pulses=%0d, required 0", res_cnt - n0);
      n_mis++;
    end
    num(7);
    run_expr(1'b0, d, e, lat);
    check_res("after_reset_eval", d, e, 8'd7, 3'd0);
  endtask

  task automatic test_div();
    logic [7:0] d; logic [2:0] e; int lat;
`ifdef POSTFIX_EVAL_DIV_EN
    num(7); num(2); opr(DIV);
    run_expr(1'b0, d, e, lat);
    check_res("div", d, e, 8'd3, 3'd0);
    num(7); num(0); opr(DIV);
    run_expr(1'b0, d, e, lat);
    check_res("div_zero_last", d, e, 8'd0, 3'd5);
    num(7); num(0); opr(DIV); num(1); opr(ADD);
    run_expr(1'b0, d, e, lat);
    check_res("div_zero_drain", d, e, 8'd0, 3'd5);
`else
    num(7); num(2); opr(DIV);
    run_expr(1'b0, d, e, lat);
    check_res("div_disabled", d, e, 8'd0, 3'd3);
`endif
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wrap();
    test_malformed();
    test_overflow();
    test_backpressure();
    test_reset_in_exec();
    test_div();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
